// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin over five input FIFOs,
// locking the output to one input until its packet's tail flit transfers.
module output_port_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              req,
    input  logic [5*DATA_WIDTH-1:0] flit_in,
    input  logic [4:0]              tail_in,
    input  logic                    ready_in,
    output logic [4:0]              pop,
    output logic [DATA_WIDTH-1:0]   flit_out,
    output logic                    valid_out,
    output logic [4:0]              grant,
    output logic                    busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [4:0] r_grant;
    logic [4:0] w_grant_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;

    logic [2:0] w_scan;
    logic [2:0] w_winner;
    logic       w_found;

    logic [2:0]            w_owner;
    logic [DATA_WIDTH-1:0] w_owner_flit;
    logic                  w_locked;
    logic                  w_valid;
    logic                  w_xfer;

    // Index order wraps 4 -> 0 so the pointer stays within 0..4.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v == 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    // Circular first-set scan of req starting at the priority pointer.
    always_comb begin
        w_scan   = r_ptr;
        w_winner = r_ptr;
        w_found  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!w_found && req[w_scan]) begin
                w_winner = w_scan;
                w_found  = 1'b1;
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    // Encode the one-hot owner into an index for muxing.
    always_comb begin
        w_owner = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (r_grant[i]) begin
                w_owner = 3'(i);
            end
        end
    end

    assign w_owner_flit = flit_in[w_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_locked     = (r_state == ST_LOCKED) && !rst;
    assign w_valid      = w_locked && req[w_owner];
    assign w_xfer       = w_valid && ready_in;

    // Output mux and pop strobe; all quiet unless locked.
    always_comb begin
        valid_out = w_valid;
        flit_out  = w_locked ? w_owner_flit : '0;
        pop       = w_xfer ? r_grant : 5'b00000;
        grant     = r_grant;
        busy      = w_locked;
    end

    // Next-state logic: lock on the scan winner, unlock on tail transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = 5'b00001 << w_winner;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_xfer && tail_in[w_owner]) begin
                    w_grant_nxt = 5'b00000;
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = wrap_inc(w_owner);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 5'b00000;
            end
        endcase
    end

    // State, owner and priority pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= 5'b00000;
            r_ptr   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed self-checking bench for output_port_arbiter.
module tb_output_port_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    req;
    logic [DW-1:0] f [5];
    logic [5*DW-1:0] flit_in;
    logic [4:0]    tail_in;
    logic          ready_in;
    logic [4:0]    pop;
    logic [DW-1:0] flit_out;
    logic          valid_out;
    logic [4:0]    grant;
    logic          busy;

    int checks = 0;
    int errors = 0;

    assign flit_in = {f[4], f[3], f[2], f[1], f[0]};

    output_port_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_in   (flit_in),
        .tail_in   (tail_in),
        .ready_in  (ready_in),
        .pop       (pop),
        .flit_out  (flit_out),
        .valid_out (valid_out),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        req      = 5'b11111;
        tail_in  = 5'b11111;
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) f[i] = 32'hC0DE_0000 | 32'(i);

        // Reset held two cycles with all requesting
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_pop", 32'(pop), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flit", flit_out, 32'h0);

        rst = 1'b0;
        #1;
        chk("idle_pop", 32'(pop), 32'h0);
        chk("idle_valid", 32'(valid_out), 32'h0);

        // Single-flit packets: L,N,E,W,S,L with a bubble between
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(5'b00001 << (n % 5)));
            chk("rr_busy", 32'(busy), 32'h1);
            chk("rr_pop", 32'(pop), 32'(5'b00001 << (n % 5)));
            chk("rr_flit", flit_out, 32'hC0DE_0000 | 32'(n % 5));
            tick();
            chk("rr_idle_grant", 32'(grant), 32'h0);
            chk("rr_idle_pop", 32'(pop), 32'h0);
            if (n == 5) begin
                // Prepare wormhole: N 3-flit packet, E waiting (ptr=1)
                req     = 5'b00110;
                tail_in = 5'b00000;
                f[1]    = 32'h1111_0001;
                f[2]    = 32'h2222_0001;
            end
        end

        tick();
        chk("wh_grant", 32'(grant), 32'h02);
        chk("wh_pop1", 32'(pop), 32'h02);
        chk("wh_flit1", flit_out, 32'h1111_0001);
        tick();
        f[1] = 32'h1111_0002;
        #1;
        chk("wh_pop2", 32'(pop), 32'h02);
        chk("wh_flit2", flit_out, 32'h1111_0002);
        tick();
        f[1]    = 32'h1111_0003;
        tail_in = 5'b00010;
        #1;
        chk("wh_pop3", 32'(pop), 32'h02);
        chk("wh_flit3", flit_out, 32'h1111_0003);
        tick();
        chk("wh_idle_grant", 32'(grant), 32'h0);
        chk("wh_idle_pop", 32'(pop), 32'h0);
        tick();
        chk("wh_e_grant", 32'(grant), 32'h04);
        tail_in = 5'b00100;
        #1;
        chk("wh_e_pop", 32'(pop), 32'h04);
        chk("wh_e_flit", flit_out, 32'h2222_0001);
        tick();
        req     = 5'b00000;
        tail_in = 5'b00000;
        f[3]    = 32'h3333_0001;
        #1;
        chk("e_done_grant", 32'(grant), 32'h0);

        // Backpressure while locked on W (ptr=3)
        req = 5'b01000;
        tick();
        chk("bp_grant", 32'(grant), 32'h08);
        chk("bp_pop1", 32'(pop), 32'h08);
        chk("bp_flit1", flit_out, 32'h3333_0001);
        tick();
        f[3]     = 32'h3333_0002;
        ready_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_hold_pop", 32'(pop), 32'h0);
            chk("bp_hold_valid", 32'(valid_out), 32'h1);
            chk("bp_hold_grant", 32'(grant), 32'h08);
            chk("bp_hold_flit", flit_out, 32'h3333_0002);
            tick();
        end
        ready_in = 1'b1;
        tail_in  = 5'b01000;
        #1;
        chk("bp_resume_pop", 32'(pop), 32'h08);
        chk("bp_resume_flit", flit_out, 32'h3333_0002);
        tick();

        // Owner gap on S with L waiting (ptr=4)
        req     = 5'b10001;
        tail_in = 5'b00000;
        f[4]    = 32'h4444_0001;
        f[0]    = 32'h0000_AAAA;
        #1;
        chk("gap_idle_grant", 32'(grant), 32'h0);
        tick();
        chk("gap_grant", 32'(grant), 32'h10);
        chk("gap_pop1", 32'(pop), 32'h10);
        chk("gap_flit1", flit_out, 32'h4444_0001);
        tick();
        req = 5'b00001;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("gap_valid", 32'(valid_out), 32'h0);
            chk("gap_pop", 32'(pop), 32'h0);
            chk("gap_hold_grant", 32'(grant), 32'h10);
            tick();
        end
        req     = 5'b10001;
        f[4]    = 32'h4444_0002;
        tail_in = 5'b10000;
        #1;
        chk("gap_tail_pop", 32'(pop), 32'h10);
        chk("gap_tail_flit", flit_out, 32'h4444_0002);
        tick();
        chk("gap_after_grant", 32'(grant), 32'h0);
        tick();
        chk("wrap_l_grant", 32'(grant), 32'h01);
        tail_in = 5'b00001;
        #1;
        chk("wrap_l_pop", 32'(pop), 32'h01);
        chk("wrap_l_flit", flit_out, 32'h0000_AAAA);
        tick();

        // Async reset mid-packet on E (ptr=1 before reset)
        req     = 5'b00100;
        tail_in = 5'b00000;
        tick();
        chk("ar_grant", 32'(grant), 32'h04);
        chk("ar_pop", 32'(pop), 32'h04);
        tick();
        chk("ar_still_locked", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_grant_now", 32'(grant), 32'h0);
        chk("ar_busy_now", 32'(busy), 32'h0);
        chk("ar_pop_now", 32'(pop), 32'h0);
        chk("ar_valid_now", 32'(valid_out), 32'h0);
        req = 5'b10001;
        tick();
        rst = 1'b0;
        #1;
        chk("ar_idle_grant", 32'(grant), 32'h0);
        tick();
        chk("ar_restart_grant", 32'(grant), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
